// File: rtl/cfg_chain_loader.sv
// Configuration scan-chain loader: accepts config words on a valid/ready
// stream, shifts them out MSB-first with a strobe per bit, and enables the
// chain outputs once every chain bit has been loaded.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_bit,
    output logic              cfg_shift,
    output logic              chain_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BL_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WL_W = $clog2(DATA_W + 1);
    localparam int unsigned DV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] w_buf_nxt;
    logic [BL_W-1:0]   r_bits_left;
    logic [BL_W-1:0]   w_bits_left_nxt;
    logic [WL_W-1:0]   r_word_left;
    logic [WL_W-1:0]   w_word_left_nxt;
    logic [DV_W-1:0]   r_div_cnt;
    logic [DV_W-1:0]   w_div_cnt_nxt;
    logic              r_cfg_bit;
    logic              w_cfg_bit_nxt;
    logic              r_cfg_shift;
    logic              w_cfg_shift_nxt;
    logic              r_chain_en;
    logic              w_chain_en_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_tick;

    // Handshake and activity flags decode straight from the state.
    assign s_ready   = (r_state == ST_FETCH);
    assign busy      = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
    assign cfg_bit   = r_cfg_bit;
    assign cfg_shift = r_cfg_shift;
    assign chain_en  = r_chain_en;
    assign done      = r_done;

    // Divider terminal count: this SHIFT cycle issues a strobe.
    assign w_tick = (r_div_cnt == DV_W'(CLK_DIV - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            r_buf       <= '0;
            r_bits_left <= '0;
            r_word_left <= '0;
            r_div_cnt   <= '0;
            r_cfg_bit   <= 1'b0;
            r_cfg_shift <= 1'b0;
            r_chain_en  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_buf       <= w_buf_nxt;
            r_bits_left <= w_bits_left_nxt;
            r_word_left <= w_word_left_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_cfg_bit   <= w_cfg_bit_nxt;
            r_cfg_shift <= w_cfg_shift_nxt;
            r_chain_en  <= w_chain_en_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state and next-value logic for the load session.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_bits_left_nxt = r_bits_left;
        w_word_left_nxt = r_word_left;
        w_div_cnt_nxt   = r_div_cnt;
        w_cfg_bit_nxt   = r_cfg_bit;
        w_cfg_shift_nxt = 1'b0;
        w_chain_en_nxt  = r_chain_en;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_FETCH;
                    w_chain_en_nxt  = 1'b0;
                    w_bits_left_nxt = BL_W'(CHAIN_LEN);
                    w_div_cnt_nxt   = '0;
                end
            end
            ST_FETCH: begin
                if (s_valid) begin
                    w_buf_nxt       = s_data;
                    // Final word may be partial: only the remaining chain bits go out.
                    w_word_left_nxt = (32'(r_bits_left) >= DATA_W) ? WL_W'(DATA_W)
                                                                   : WL_W'(r_bits_left);
                    w_state_nxt     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    w_cfg_bit_nxt   = r_buf[DATA_W-1];
                    w_cfg_shift_nxt = 1'b1;
                    w_buf_nxt       = r_buf << 1;
                    w_word_left_nxt = r_word_left - WL_W'(1);
                    w_bits_left_nxt = r_bits_left - BL_W'(1);
                    w_div_cnt_nxt   = '0;
                    if (r_word_left == WL_W'(1)) begin
                        w_state_nxt = (r_bits_left == BL_W'(1)) ? ST_DONE : ST_FETCH;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DV_W'(1);
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
                if (start) begin
                    // A new session begins immediately; the chain is not yet valid.
                    w_state_nxt     = ST_FETCH;
                    w_chain_en_nxt  = 1'b0;
                    w_bits_left_nxt = BL_W'(CHAIN_LEN);
                    w_div_cnt_nxt   = '0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_chain_en_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: three instances cover the basic
// 8-bit chain, a 12-bit chain with a partial tail word, and a divided clock.
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    logic res = 1'b1;

    always #5 clk = ~clk;

    // Instance A: CHAIN_LEN=8, DATA_W=8, CLK_DIV=1
    logic       a_start = 1'b0, a_valid = 1'b0;
    logic [7:0] a_data  = '0;
    logic       a_ready, a_bit, a_shift, a_en, a_busy, a_done;
    // Instance B: CHAIN_LEN=12, DATA_W=8, CLK_DIV=1
    logic       b_start = 1'b0, b_valid = 1'b0;
    logic [7:0] b_data  = '0;
    logic       b_ready, b_bit, b_shift, b_en, b_busy, b_done;
    // Instance C: CHAIN_LEN=12, DATA_W=8, CLK_DIV=3
    logic       c_start = 1'b0, c_valid = 1'b0;
    logic [7:0] c_data  = '0;
    logic       c_ready, c_bit, c_shift, c_en, c_busy, c_done;

    cfg_chain_loader #(.CHAIN_LEN(8), .DATA_W(8), .CLK_DIV(1)) u_a (
        .clk(clk), .res(res), .start(a_start), .s_data(a_data), .s_valid(a_valid),
        .s_ready(a_ready), .cfg_bit(a_bit), .cfg_shift(a_shift), .chain_en(a_en),
        .busy(a_busy), .done(a_done)
    );
    cfg_chain_loader #(.CHAIN_LEN(12), .DATA_W(8), .CLK_DIV(1)) u_b (
        .clk(clk), .res(res), .start(b_start), .s_data(b_data), .s_valid(b_valid),
        .s_ready(b_ready), .cfg_bit(b_bit), .cfg_shift(b_shift), .chain_en(b_en),
        .busy(b_busy), .done(b_done)
    );
    cfg_chain_loader #(.CHAIN_LEN(12), .DATA_W(8), .CLK_DIV(3)) u_c (
        .clk(clk), .res(res), .start(c_start), .s_data(c_data), .s_valid(c_valid),
        .s_ready(c_ready), .cfg_bit(c_bit), .cfg_shift(c_shift), .chain_en(c_en),
        .busy(c_busy), .done(c_done)
    );

    // Model chains (shift left, new bit at bit 0) plus strobe/accept counters,
    // sampled 1 ns before each rising edge.
    logic [15:0] a_chain = '0, b_chain = '0, c_chain = '0;
    int a_strb = 0, b_strb = 0, c_strb = 0;
    int b_acc = 0, c_acc = 0;

    always begin
        @(negedge clk);
        #4;
        if (a_shift) begin
            a_chain = {a_chain[14:0], a_bit};
            a_strb++;
        end
        if (b_shift) begin
            b_chain = {b_chain[14:0], b_bit};
            b_strb++;
        end
        if (c_shift) begin
            c_chain = {c_chain[14:0], c_bit};
            c_strb++;
        end
        if (b_valid && b_ready) b_acc++;
        if (c_valid && c_ready) c_acc++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pat;
    int s0, acc0;

    initial begin
        // Reset held 3 cycles, then release
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_shift", 32'(a_shift), 32'd0);
        chk("rst_en",    32'(a_en),    32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_done",  32'(a_done),  32'd0);

        // Basic load of 0xA5 on A
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_fetch_ready", 32'(a_ready), 32'd1);
        chk("a_fetch_busy",  32'(a_busy),  32'd1);
        a_valid = 1'b1;
        a_data  = 8'hA5;
        s0 = a_strb;
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_shift_ready", 32'(a_ready), 32'd0);
        chk("a_first_gap",   32'(a_shift), 32'd0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("a_strobe", 32'(a_shift), 32'd1);
            chk("a_bit",    32'(a_bit),   32'(pat[7-i]));
        end
        @(negedge clk);
        chk("a_done",   32'(a_done),       32'd1);
        chk("a_en",     32'(a_en),         32'd1);
        chk("a_idle",   32'(a_busy),       32'd0);
        chk("a_chain",  32'(a_chain[7:0]), 32'hA5);
        chk("a_count",  32'(a_strb - s0),  32'd8);
        @(negedge clk);
        chk("a_done_pulse", 32'(a_done), 32'd0);
        chk("a_en_hold",    32'(a_en),   32'd1);

        // Reset after 4 strobes, then a clean load of 0x5A
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'hFF;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("mid_rst_shift", 32'(a_shift), 32'd0);
        chk("mid_rst_bit",   32'(a_bit),   32'd0);
        chk("mid_rst_en",    32'(a_en),    32'd0);
        chk("mid_rst_busy",  32'(a_busy),  32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_done",  32'(a_done),  32'd0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h5A;
        s0 = a_strb;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("reload_en_low", 32'(a_en), 32'd0);
        @(negedge clk);
        chk("reload_done",  32'(a_done),       32'd1);
        chk("reload_en",    32'(a_en),         32'd1);
        chk("reload_chain", 32'(a_chain[7:0]), 32'h5A);
        chk("reload_count", 32'(a_strb - s0),  32'd8);

        // start pulsed during SHIFT is ignored
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h3C;
        s0 = a_strb;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ign_done",  32'(a_done),       32'd1);
        chk("ign_count", 32'(a_strb - s0),  32'd8);
        chk("ign_chain", 32'(a_chain[7:0]), 32'h3C);
        @(negedge clk);
        chk("ign_en", 32'(a_en), 32'd1);
        // Second start after DONE drops chain_en until the new done
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("restart_en_drop", 32'(a_en),    32'd0);
        chk("restart_ready",   32'(a_ready), 32'd1);
        a_valid = 1'b1;
        a_data  = 8'h81;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("restart_en_low", 32'(a_en), 32'd0);
        @(negedge clk);
        chk("restart_done",  32'(a_done),       32'd1);
        chk("restart_en",    32'(a_en),         32'd1);
        chk("restart_chain", 32'(a_chain[7:0]), 32'h81);

        // B: 12-bit chain, words 0xF0 then 0x3C; source keeps valid high throughout
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_data  = 8'hF0;
        s0   = b_strb;
        acc0 = b_acc;
        @(negedge clk);
        b_data = 8'h3C;
        for (int n = 3; n <= 15; n++) begin
            @(negedge clk);
            chk("b_strobe", 32'(b_shift), (n == 11) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        chk("b_done",  32'(b_done),        32'd1);
        chk("b_en",    32'(b_en),          32'd1);
        chk("b_chain", 32'(b_chain[11:0]), 32'hF03);
        chk("b_count", 32'(b_strb - s0),   32'd12);
        repeat (3) @(negedge clk);
        chk("b_accepts", 32'(b_acc - acc0), 32'd2);
        b_valid = 1'b0;

        // C: CLK_DIV=3, second word held back 5 cycles
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        c_valid = 1'b1;
        c_data  = 8'hF0;
        s0   = c_strb;
        acc0 = c_acc;
        for (int n = 2; n <= 26; n++) begin
            @(negedge clk);
            if (n == 2) c_valid = 1'b0;
            chk("c_strobe", 32'(c_shift), (n >= 5 && (n - 5) % 3 == 0) ? 32'd1 : 32'd0);
        end
        for (int n = 27; n <= 31; n++) begin
            @(negedge clk);
            chk("c_stall_strobe", 32'(c_shift), 32'd0);
            chk("c_stall_ready",  32'(c_ready), 32'd1);
        end
        chk("c_stall_count", 32'(c_strb - s0), 32'd8);
        c_valid = 1'b1;
        c_data  = 8'h3C;
        @(negedge clk);
        c_valid = 1'b0;
        for (int n = 33; n <= 44; n++) begin
            @(negedge clk);
            chk("c_tail_strobe", 32'(c_shift), (n == 35 || n == 38 || n == 41 || n == 44) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("c_done",    32'(c_done),        32'd1);
        chk("c_en",      32'(c_en),          32'd1);
        chk("c_chain",   32'(c_chain[11:0]), 32'hF03);
        chk("c_count",   32'(c_strb - s0),   32'd12);
        chk("c_accepts", 32'(c_acc - acc0),  32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
